// File: rtl/l2_arbiter_if.sv
// -----------------------------------------------------------------------------
// l2_arbiter_if
// Bundles every request/response signal around the L2 arbiter: the two L1
// requester ports (instruction side "I", data side "D"), the shared L2 request
// port and the grant indicator.
//   slave  modport : the arbiter's view (requests and L2 completion in,
//                    ready pulses, read data, L2 request and grant out)
//   master modport : the environment's view (requesters plus L2 model)
// Parameters: TAG_W tag width, IDX_W set-index width, LINE_W line width.
// -----------------------------------------------------------------------------
interface l2_arbiter_if #(
  parameter int TAG_W  = 18,
  parameter int IDX_W  = 8,
  parameter int LINE_W = 512
);
  // Instruction-L1 requester
  logic              read_I_L2;
  logic              write_I_L2;
  logic [TAG_W-1:0]  tag_I_L2;
  logic [IDX_W-1:0]  index_I_L2;
  logic [LINE_W-1:0] write_data_I_L2;
  logic              ready_L2_I;
  logic [LINE_W-1:0] read_data_L2_I;

  // Data-L1 requester
  logic              read_D_L2;
  logic              write_D_L2;
  logic [TAG_W-1:0]  tag_D_L2;
  logic [IDX_W-1:0]  index_D_L2;
  logic [LINE_W-1:0] write_data_D_L2;
  logic              ready_L2_D;
  logic [LINE_W-1:0] read_data_L2_D;

  // Shared L2 port
  logic              read_L1_L2;
  logic              write_L1_L2;
  logic [TAG_W-1:0]  tag_L1_L2;
  logic [IDX_W-1:0]  index_L1_L2;
  logic [LINE_W-1:0] write_data;
  logic              ready_L2_L1;
  logic [LINE_W-1:0] read_data_L2_L1;

  // Current owner: 00 none, 01 I, 10 D
  logic [1:0]        grant_o;

  modport slave (
    input  read_I_L2, write_I_L2, tag_I_L2, index_I_L2, write_data_I_L2,
    input  read_D_L2, write_D_L2, tag_D_L2, index_D_L2, write_data_D_L2,
    input  ready_L2_L1, read_data_L2_L1,
    output ready_L2_I, read_data_L2_I, ready_L2_D, read_data_L2_D,
    output read_L1_L2, write_L1_L2, tag_L1_L2, index_L1_L2, write_data,
    output grant_o
  );

  modport master (
    output read_I_L2, write_I_L2, tag_I_L2, index_I_L2, write_data_I_L2,
    output read_D_L2, write_D_L2, tag_D_L2, index_D_L2, write_data_D_L2,
    output ready_L2_L1, read_data_L2_L1,
    input  ready_L2_I, read_data_L2_I, ready_L2_D, read_data_L2_D,
    input  read_L1_L2, write_L1_L2, tag_L1_L2, index_L1_L2, write_data,
    input  grant_o
  );
endinterface

// File: rtl/l2_arbiter.sv
// -----------------------------------------------------------------------------
// l2_arbiter
// Arbitrates the instruction-L1 and data-L1 requesters onto a single L2 port.
// One transaction is in flight at a time: IDLE -> BUSY (L2 request held from
// latch registers) -> RESP (one cycle, requester drops its strobes) -> IDLE.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   l2_bus  l2_arbiter_if.slave (requesters, shared L2 port, grant_o)
// Configuration macro:
//   L2_ARB_FIXED_PRIO_EN  defined   : D always wins over I, no last-served state
//                         undefined : round-robin, D wins first after reset
// -----------------------------------------------------------------------------
module l2_arbiter #(
  parameter int TAG_W  = 18,
  parameter int IDX_W  = 8,
  parameter int LINE_W = 512
) (
  input logic          clk,
  input logic          rst,
  l2_arbiter_if.slave  l2_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_t;

  state_t            r_state;
  state_t            w_next_state;
  owner_t            r_owner;

  logic              w_pend_i;
  logic              w_pend_d;
  logic              w_pick_d;
  logic              w_start;
  logic              w_complete;

  // Payload of whichever requester wins this cycle
  logic              w_sel_rd;
  logic              w_sel_wr;
  logic [TAG_W-1:0]  w_sel_tag;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [LINE_W-1:0] w_sel_wdata;

  logic              r_read;
  logic              r_write;
  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_index;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_rdata_i;
  logic [LINE_W-1:0] r_rdata_d;
  logic              r_ready_i;
  logic              r_ready_d;

  assign w_pend_i = l2_bus.read_I_L2 | l2_bus.write_I_L2;
  assign w_pend_d = l2_bus.read_D_L2 | l2_bus.write_D_L2;

`ifdef L2_ARB_FIXED_PRIO_EN
  // Data side always wins a tie; nothing to remember between transactions.
  assign w_pick_d = w_pend_d;
`else
  // 1 when D was the last requester served; reset value means "I served last"
  // so D wins the first tie after reset.
  logic r_last_d;

  // D wins when it is alone, or on a tie when I was served last.
  assign w_pick_d = w_pend_d & (~w_pend_i | ~r_last_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (r_state == S_RESP) begin
      r_last_d <= (r_owner == OWN_D);
    end
  end
`endif

  assign w_sel_rd    = w_pick_d ? l2_bus.read_D_L2       : l2_bus.read_I_L2;
  assign w_sel_wr    = w_pick_d ? l2_bus.write_D_L2      : l2_bus.write_I_L2;
  assign w_sel_tag   = w_pick_d ? l2_bus.tag_D_L2        : l2_bus.tag_I_L2;
  assign w_sel_idx   = w_pick_d ? l2_bus.index_D_L2      : l2_bus.index_I_L2;
  assign w_sel_wdata = w_pick_d ? l2_bus.write_data_D_L2 : l2_bus.write_data_I_L2;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. ready_L2_L1 is only looked at in BUSY, so a spurious
  // completion in IDLE or RESP has no effect.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_start      = 1'b0;
    w_complete   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pend_i | w_pend_d) begin
          w_start      = 1'b1;
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        if (l2_bus.ready_L2_L1) begin
          w_complete   = 1'b1;
          w_next_state = S_RESP;
        end
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: latch the winning request, hold it through BUSY, capture the
  // returned line and pulse the owner's ready on completion.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      r_owner   <= OWN_NONE;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_tag     <= '0;
      r_index   <= '0;
      r_wdata   <= '0;
      r_rdata_i <= '0;
      r_rdata_d <= '0;
      r_ready_i <= 1'b0;
      r_ready_d <= 1'b0;
    end else begin
      r_ready_i <= 1'b0;
      r_ready_d <= 1'b0;
      if (w_start) begin
        r_owner <= w_pick_d ? OWN_D : OWN_I;
        // A combined read+write request goes out as a write only.
        r_read  <= w_sel_rd & ~w_sel_wr;
        r_write <= w_sel_wr;
        r_tag   <= w_sel_tag;
        r_index <= w_sel_idx;
        r_wdata <= w_sel_wdata;
      end
      if (w_complete) begin
        r_read  <= 1'b0;
        r_write <= 1'b0;
        if (r_owner == OWN_D) begin
          r_rdata_d <= l2_bus.read_data_L2_L1;
          r_ready_d <= 1'b1;
        end else begin
          r_rdata_i <= l2_bus.read_data_L2_L1;
          r_ready_i <= 1'b1;
        end
      end
      if (r_state == S_RESP) begin
        r_owner <= OWN_NONE;
      end
    end
  end

  assign l2_bus.read_L1_L2     = r_read;
  assign l2_bus.write_L1_L2    = r_write;
  assign l2_bus.tag_L1_L2      = r_tag;
  assign l2_bus.index_L1_L2    = r_index;
  assign l2_bus.write_data     = r_wdata;
  assign l2_bus.ready_L2_I     = r_ready_i;
  assign l2_bus.ready_L2_D     = r_ready_d;
  assign l2_bus.read_data_L2_I = r_rdata_i;
  assign l2_bus.read_data_L2_D = r_rdata_d;
  assign l2_bus.grant_o        = r_owner;

endmodule
